// File: rtl/phase_seq_pkg.sv
// Shared types and constants for the phase sequencer.
package phase_seq_pkg;

    // Sequencer control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } seq_state_e;

    // Duration every table entry holds after reset, in ticks.
    localparam int DEF_DUR = 1;

endpackage

// File: rtl/phase_sequencer_tick_gen.sv
// Tick prescaler: counts 0..TICK_DIV-1 while enabled and flags the wrap cycle.
// The flag is combinational so the sequencer can act on the wrap in the same
// cycle; the sequencer registers it before it leaves the block.
module tick_gen
    import phase_seq_pkg::*;
#(
    parameter int TICK_DIV = 50
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             at_max;

    assign at_max = (count_reg == CNT_MAX);

    // Clear wins over counting; counting wraps back to zero at the top.
    always_comb begin
        count_next = count_reg;
        if (clr_i) begin
            count_next = '0;
        end else if (en_i) begin
            count_next = at_max ? '0 : count_reg + 1'b1;
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // A clear in the same cycle suppresses the wrap.
    assign tick_o = en_i & ~clr_i & at_max;

endmodule

// File: rtl/phase_sequencer.sv
// Programmable multi-phase timing controller: steps phase_o through the
// sequence, holding each phase for its programmed number of prescaler ticks,
// with start / stop / pause / loop control. All outputs are registered.
module phase_sequencer
    import phase_seq_pkg::*;
#(
    parameter int NUM_PHASES = 4,
    parameter int TICK_DIV   = 50,
    parameter int DUR_W      = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          cfg_we_i,
    input  logic [$clog2(NUM_PHASES)-1:0] cfg_addr_i,
    input  logic [DUR_W-1:0]              cfg_data_i,
    input  logic                          start_i,
    input  logic                          stop_i,
    input  logic                          pause_i,
    input  logic                          loop_i,
    output logic                          busy_o,
    output logic [$clog2(NUM_PHASES)-1:0] phase_o,
    output logic                          phase_start_o,
    output logic                          tick_o,
    output logic                          done_o
);

    localparam int PH_W = $clog2(NUM_PHASES);
    localparam logic [PH_W-1:0]  LAST_PHASE = PH_W'(NUM_PHASES - 1);
    localparam logic [PH_W:0]    PHASE_CNT  = (PH_W + 1)'(NUM_PHASES);
    localparam logic [DUR_W-1:0] DUR_ONE    = DUR_W'(1);
    localparam logic [DUR_W-1:0] DUR_RESET  = DUR_W'(DEF_DUR);

    // A programmed duration of zero still spends one tick in the phase.
    function automatic logic [DUR_W-1:0] eff_dur(input logic [DUR_W-1:0] d);
        return (d == '0) ? DUR_ONE : d;
    endfunction

    seq_state_e        state_reg, state_next;
    logic [PH_W-1:0]   phase_reg, phase_next;
    logic [DUR_W-1:0]  remaining_reg, remaining_next;
    logic              phase_start_reg, phase_start_next;
    logic              done_reg, done_next;
    logic              busy_reg;
    logic              tick_reg;

    logic [DUR_W-1:0]      dur_reg [NUM_PHASES];
    logic [NUM_PHASES-1:0] entry_we;
    logic                  cfg_ok;

    logic            is_busy;
    logic            start_accept;
    logic            stop_req;
    logic            count_en;
    logic            count_clr;
    logic            tick_wrap;
    logic [PH_W-1:0] phase_inc;

    assign is_busy      = (state_reg != IDLE);
    assign start_accept = (state_reg == IDLE) && start_i && !stop_i;
    assign stop_req     = is_busy && stop_i;
    assign phase_inc    = phase_reg + 1'b1;

    // The prescaler runs whenever a sequence is active and pause_i is low.
    // Counting on the resume cycle (still in PAUSE) makes a pause of N
    // cycles delay the rest of the sequence by exactly N cycles.
    assign count_en  = is_busy && !pause_i;
    assign count_clr = start_accept || stop_req;

    // Table writes are only taken while idle and for an existing phase index.
    assign cfg_ok = cfg_we_i && (state_reg == IDLE) && ({1'b0, cfg_addr_i} < PHASE_CNT);

    generate
        for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_entry_we
            assign entry_we[gi] = cfg_ok && (cfg_addr_i == PH_W'(gi));
        end
    endgenerate

    // Duration table; reset restores every entry to the default duration.
    // A write coincident with an accepted start lands here while the load of
    // remaining_reg uses the value read before the write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                dur_reg[i] <= DUR_RESET;
            end
        end else begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                if (entry_we[i]) begin
                    dur_reg[i] <= cfg_data_i;
                end
            end
        end
    end

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (count_clr),
        .en_i   (count_en),
        .tick_o (tick_wrap)
    );

    // Next-state and output decode: start, stop (highest priority), pause,
    // and the per-tick phase advance.
    always_comb begin
        state_next       = state_reg;
        phase_next       = phase_reg;
        remaining_next   = remaining_reg;
        phase_start_next = 1'b0;
        done_next        = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (start_accept) begin
                    state_next       = RUN;
                    phase_next       = '0;
                    remaining_next   = eff_dur(dur_reg[0]);
                    phase_start_next = 1'b1;
                end
            end

            RUN, PAUSE: begin
                if (stop_i) begin
                    state_next     = IDLE;
                    phase_next     = '0;
                    remaining_next = '0;
                end else if (pause_i) begin
                    state_next = PAUSE;
                end else begin
                    state_next = RUN;
                    if (tick_wrap) begin
                        if (remaining_reg > DUR_ONE) begin
                            remaining_next = remaining_reg - 1'b1;
                        end else if (phase_reg != LAST_PHASE) begin
                            phase_next       = phase_inc;
                            remaining_next   = eff_dur(dur_reg[phase_inc]);
                            phase_start_next = 1'b1;
                        end else if (loop_i) begin
                            phase_next       = '0;
                            remaining_next   = eff_dur(dur_reg[0]);
                            phase_start_next = 1'b1;
                        end else begin
                            state_next     = IDLE;
                            phase_next     = '0;
                            remaining_next = '0;
                            done_next      = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_next     = IDLE;
                phase_next     = '0;
                remaining_next = '0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg       <= IDLE;
            phase_reg       <= '0;
            remaining_reg   <= '0;
            phase_start_reg <= 1'b0;
            done_reg        <= 1'b0;
            busy_reg        <= 1'b0;
            tick_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            phase_reg       <= phase_next;
            remaining_reg   <= remaining_next;
            phase_start_reg <= phase_start_next;
            done_reg        <= done_next;
            busy_reg        <= (state_next != IDLE);
            tick_reg        <= tick_wrap;
        end
    end

    assign busy_o        = busy_reg;
    assign phase_o       = phase_reg;
    assign phase_start_o = phase_start_reg;
    assign tick_o        = tick_reg;
    assign done_o        = done_reg;

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer. Each run's expected phase_start_o /
// done_o timeline is computed from the durations, pause window and stop point
// with plain arithmetic and queued; a monitor pops and compares on every pulse.
module tb_phase_sequencer;

    localparam int NP = 4;
    localparam int TD = 4;
    localparam int DW = 8;

    logic          clk_i      = 1'b0;
    logic          rst_ni     = 1'b0;
    logic          cfg_we_i   = 1'b0;
    logic [1:0]    cfg_addr_i = '0;
    logic [DW-1:0] cfg_data_i = '0;
    logic          start_i    = 1'b0;
    logic          stop_i     = 1'b0;
    logic          pause_i    = 1'b0;
    logic          loop_i     = 1'b0;
    logic          busy_o;
    logic [1:0]    phase_o;
    logic          phase_start_o;
    logic          tick_o;
    logic          done_o;

    phase_sequencer #(
        .NUM_PHASES (NP),
        .TICK_DIV   (TD),
        .DUR_W      (DW)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .cfg_we_i      (cfg_we_i),
        .cfg_addr_i    (cfg_addr_i),
        .cfg_data_i    (cfg_data_i),
        .start_i       (start_i),
        .stop_i        (stop_i),
        .pause_i       (pause_i),
        .loop_i        (loop_i),
        .busy_o        (busy_o),
        .phase_o       (phase_o),
        .phase_start_o (phase_start_o),
        .tick_o        (tick_o),
        .done_o        (done_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit is_done;
        int phase;
    } evt_t;

    evt_t exp_q[$];
    int   tbl[NP];
    int   n_total  = 0;
    int   n_pass   = 0;
    int   tick_cnt = 0;

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic void push_evt(input int c, input bit d, input int p);
        evt_t e;
        e.cyc = c;
        e.is_done = d;
        e.phase = p;
        exp_q.push_back(e);
    endfunction

    // Monitor: one line per observed transaction, compared against the queue.
    always @(negedge clk_i) begin
        evt_t e;
        if (tick_o) tick_cnt++;
        if (rst_ni && (phase_start_o || done_o)) begin
            $display("cycle %0d: %s phase=%0d busy=%0d", cyc,
                     done_o ? "done" : "phase_start", phase_o, busy_o);
            if (exp_q.size() == 0) begin
                chk("unexpected_event", cyc, -1);
            end else begin
                e = exp_q.pop_front();
                chk("event_cycle", cyc, e.cyc);
                chk("event_is_done", int'(done_o), int'(e.is_done));
                if (e.is_done) chk("done_busy", int'(busy_o), 0);
                else chk("event_phase", int'(phase_o), e.phase);
            end
        end
    end

    function automatic int shift_t(input int t, input int p_abs, input int plen);
        return (p_abs >= 0 && t > p_abs) ? t + plen : t;
    endfunction

    task automatic cfg_write(input int addr, input int val);
        @(negedge clk_i);
        cfg_we_i   = 1'b1;
        cfg_addr_i = 2'(addr);
        cfg_data_i = DW'(val);
        @(negedge clk_i);
        cfg_we_i = 1'b0;
        tbl[addr] = val;
    endtask

    // One sequence run. Offsets are relative to the start cycle; -1 disables.
    task automatic do_run(input int passes, input int pause_at, input int plen,
                          input int stop_at, input int reset_at, input int busy_wr_at,
                          input bit cfg_at_start, input int cfg_val);
        int s, t, tot, cut, end_c, last_pass_c, p_abs, et;
        int d[NP];
        @(negedge clk_i);
        s = cyc;
        tot = 0;
        for (int k = 0; k < NP; k++) begin
            d[k] = (tbl[k] < 1) ? 1 : tbl[k];
            tot += d[k];
        end
        p_abs = (pause_at >= 0) ? s + pause_at : -1;
        cut = (stop_at >= 0) ? s + stop_at : ((reset_at >= 0) ? s + reset_at : 32'h7fff_ffff);
        t = s + 1;
        for (int p = 0; p < passes; p++) begin
            for (int k = 0; k < NP; k++) begin
                et = shift_t(t, p_abs, plen);
                if (et <= cut) push_evt(et, 1'b0, k);
                t += d[k] * TD;
            end
        end
        et = shift_t(t, p_abs, plen);
        if (et <= cut) push_evt(et, 1'b1, 0);
        if (stop_at >= 0) end_c = s + stop_at + 1;
        else if (reset_at >= 0) end_c = s + reset_at;
        else end_c = et;
        last_pass_c = shift_t(s + 1 + (passes - 1) * tot * TD, p_abs, plen);

        start_i  = 1'b1;
        loop_i   = (passes > 1);
        tick_cnt = 0;
        if (cfg_at_start) begin
            cfg_we_i   = 1'b1;
            cfg_addr_i = 2'd0;
            cfg_data_i = DW'(cfg_val);
            tbl[0] = cfg_val;
        end

        while (cyc < end_c + 2) begin
            @(negedge clk_i);
            start_i  = (cyc == s + 5);
            cfg_we_i = (busy_wr_at >= 0 && cyc == s + busy_wr_at);
            if (cfg_we_i) begin
                cfg_addr_i = 2'd2;
                cfg_data_i = 8'd7;
            end
            pause_i = (pause_at >= 0 && cyc >= s + pause_at && cyc < s + pause_at + plen);
            stop_i  = (stop_at >= 0 && cyc == s + stop_at);
            if (passes > 1 && cyc >= last_pass_c) loop_i = 1'b0;
            if (pause_at >= 0 && cyc > s + pause_at && cyc <= s + pause_at + plen)
                chk("no_tick_in_pause", int'(tick_o), 0);
            if (stop_at >= 0 && cyc == s + stop_at + 1) begin
                chk("stop_busy", int'(busy_o), 0);
                chk("stop_phase", int'(phase_o), 0);
            end
            if (reset_at >= 0 && cyc == s + reset_at) begin
                #2 rst_ni = 1'b0;
                #1;
                chk("arst_busy", int'(busy_o), 0);
                chk("arst_phase", int'(phase_o), 0);
                chk("arst_phase_start", int'(phase_start_o), 0);
                chk("arst_tick", int'(tick_o), 0);
                chk("arst_done", int'(done_o), 0);
                exp_q.delete();
                for (int k = 0; k < NP; k++) tbl[k] = 1;
                start_i = 1'b0; stop_i = 1'b0; pause_i = 1'b0; loop_i = 1'b0; cfg_we_i = 1'b0;
                @(negedge clk_i);
                rst_ni = 1'b1;
                break;
            end
        end
        start_i = 1'b0; stop_i = 1'b0; pause_i = 1'b0; loop_i = 1'b0; cfg_we_i = 1'b0;
        if (reset_at < 0) begin
            chk("queue_drained", exp_q.size(), 0);
            chk("idle_busy", int'(busy_o), 0);
            chk("idle_phase", int'(phase_o), 0);
            if (stop_at < 0) chk("tick_count", tick_cnt, passes * tot);
        end
    endtask

    initial begin
        int mode;
        for (int k = 0; k < NP; k++) tbl[k] = 1;

        // Reset state.
        @(negedge clk_i);
        chk("reset_busy", int'(busy_o), 0);
        chk("reset_phase", int'(phase_o), 0);
        chk("reset_phase_start", int'(phase_start_o), 0);
        chk("reset_tick", int'(tick_o), 0);
        chk("reset_done", int'(done_o), 0);
        rst_ni = 1'b1;

        cfg_write(0, 2); cfg_write(1, 1); cfg_write(2, 3); cfg_write(3, 1);

        do_run(1, -1, 0, -1, -1, -1, 1'b0, 0);      // nominal
        do_run(2, -1, 0, -1, -1, -1, 1'b0, 0);      // loop then end
        do_run(1, 10, 10, -1, -1, -1, 1'b0, 0);     // pause 10 cycles in phase 1
        do_run(1, -1, 0, 16, -1, 3, 1'b0, 0);       // stop in phase 2, busy write ignored

        // start and stop together while idle: stay idle
        @(negedge clk_i);
        start_i = 1'b1; stop_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0; stop_i = 1'b0;
        chk("start_stop_busy", int'(busy_o), 0);
        @(negedge clk_i);
        chk("start_stop_busy2", int'(busy_o), 0);
        chk("start_stop_phase", int'(phase_o), 0);

        cfg_write(1, 0);                            // zero duration acts as one tick
        do_run(1, -1, 0, -1, -1, -1, 1'b0, 0);
        do_run(1, -1, 0, -1, -1, -1, 1'b1, 1);      // write with start: old value this run
        do_run(1, -1, 0, -1, -1, -1, 1'b0, 0);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < NP; k++) cfg_write(k, int'($urandom_range(0, 3)));
            mode = int'($urandom_range(0, 3));
            case (mode)
                0: do_run(1, -1, 0, -1, -1, -1, 1'b0, 0);
                1: do_run(int'($urandom_range(2, 3)), -1, 0, -1, -1, -1, 1'b0, 0);
                2: do_run(1, int'($urandom_range(2, 14)), int'($urandom_range(1, 8)), -1, -1, -1, 1'b0, 0);
                default: do_run(1, -1, 0, int'($urandom_range(7, 15)), -1, -1, 1'b0, 0);
            endcase
        end

        do_run(1, -1, 0, -1, 12, -1, 1'b0, 0);      // async reset mid run
        do_run(1, -1, 0, -1, -1, -1, 1'b0, 0);      // defaults after reset: done at +17

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
